// File: rtl/alu_pkg.sv
// alu_pkg: shared operation codes, FSM state encoding and helper constants
// for the sequential ALU and its combinational core.
package alu_pkg;

  // Operation codes presented on funcsel. For the 0xxx group, bit 2 selects
  // the inverted-B / carry-in form of the same operation.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_ANDN = 4'b0100,
    OP_ORN  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLTB = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_SRL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_MUL  = 4'b1100,
    OP_RSV0 = 4'b1101,
    OP_RSV1 = 4'b1110,
    OP_RSV2 = 4'b1111
  } alu_op_t;

  // Control FSM: IDLE accepts work, BUSY iterates the shift-add multiply.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Bit of the op code that inverts B and injects carry-in for the 0xxx group.
  localparam int INV_BIT = 2;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath for every single-cycle operation.
// Produces the WIDTH-bit result plus adder carry-out and signed overflow;
// MUL and reserved codes yield zero here (MUL is handled iteratively above).
module alu_core
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_t          i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [3:0]              w_code;
  logic [WIDTH-1:0]        w_b_eff;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH-1:0]        w_diff;
  logic                    w_sum_ovf;
  logic                    w_diff_ovf;
  logic                    w_slt;
  logic [SHW-1:0]          w_shamt;
  logic signed [WIDTH-1:0] w_a_s;

  assign w_code  = i_op;
  assign w_b_eff = w_code[INV_BIT] ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_code[INV_BIT]};

  // Overflow when both adder inputs share a sign that the sum does not.
  assign w_sum_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  // Both SLT codes compare through A-B regardless of the invert bit;
  // sign xor overflow gives the true signed less-than.
  assign w_diff     = i_a - i_b;
  assign w_diff_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != i_a[WIDTH-1]);
  assign w_slt      = w_diff[WIDTH-1] ^ w_diff_ovf;

  // Shift amount comes from the low bits of B only.
  assign w_shamt = i_b[SHW-1:0];
  assign w_a_s   = i_a;

  // Operation select; carry/overflow are only meaningful for ADD/SUB.
  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_op)
      OP_AND, OP_ANDN: o_result = i_a & w_b_eff;
      OP_OR,  OP_ORN:  o_result = i_a | w_b_eff;
      OP_ADD, OP_SUB: begin
        o_result   = w_sum[WIDTH-1:0];
        o_carry    = w_sum[WIDTH];
        o_overflow = w_sum_ovf;
      end
      OP_SLT, OP_SLTB: o_result = {{(WIDTH-1){1'b0}}, w_slt};
      OP_XOR:          o_result = i_a ^ i_b;
      OP_SLL:          o_result = i_a << w_shamt;
      OP_SRL:          o_result = i_a >> w_shamt;
      OP_SRA:          o_result = w_a_s >>> w_shamt;
      default:         o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags. Single-cycle ops
// complete one edge after accept; MUL runs a WIDTH-cycle shift-add loop.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [3:0]       funcsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;
  logic             r_out_valid;

  alu_op_t          w_op;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_core_result;
  logic             w_core_carry;
  logic             w_core_overflow;

  assign w_op     = alu_op_t'(funcsel);
  assign w_is_mul = (w_op == OP_MUL);

  // Accept only from IDLE and only when the output slot is free or draining.
  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready) && !reset;
  assign w_accept = in_valid && in_ready;

  // One shift-add step: the final step's sum is what gets registered.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last     = (r_cnt == SHW'(WIDTH - 1));

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a        (operandA),
    .i_b        (operandB),
    .i_op       (w_op),
    .o_result   (w_core_result),
    .o_carry    (w_core_carry),
    .o_overflow (w_core_overflow)
  );

  // Control FSM, multiply iteration and output registers (result/flags/valid).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_mcand     <= operandA;
              r_mplier    <= operandB;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_state     <= BUSY;
            end else begin
              r_result    <= w_core_result;
              r_zero      <= (w_core_result == '0);
              r_negative  <= w_core_result[WIDTH-1];
              r_carry     <= w_core_carry;
              r_overflow  <= w_core_overflow;
              r_out_valid <= 1'b1;
            end
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last) begin
            r_cnt       <= '0;
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_negative  <= w_acc_next[WIDTH-1];
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + SHW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;

endmodule
